// File: rtl/priority_enc_4bit.sv
// 4-to-2 priority encoder with registered index and valid outputs.
// Bit 3 of D has the highest priority; Y is meaningful only when valid is high.
module priority_enc_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] D,
   output logic [1:0] Y,
   output logic       valid
);

   logic [1:0] w_yNext;
   logic       w_validNext;
   logic [1:0] r_y;
   logic       r_valid;

   // An all-zero D encodes to 00 with valid low, so Y=00 alone is ambiguous.
   always_comb begin
      w_yNext     = 2'b00;
      w_validNext = |D;
      casez (D)
         4'b1???: w_yNext = 2'b11;
         4'b01??: w_yNext = 2'b10;
         4'b001?: w_yNext = 2'b01;
         default: w_yNext = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y     <= 2'b00;
         r_valid <= 1'b0;
      end else begin
         r_y     <= w_yNext;
         r_valid <= w_validNext;
      end
   end

   assign Y     = r_y;
   assign valid = r_valid;

endmodule

// File: tb/tb_priority_enc_4bit.sv
// Scoreboard bench for priority_enc_4bit: stimulus pushes expected results,
// a monitor pops and compares them one cycle later.
module tb_priority_enc_4bit;

   typedef struct {
      logic [1:0] y;
      logic       v;
   } expT;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] D   = 4'b0000;
   logic [1:0] Y;
   logic       valid;

   expT expQ[$];
   int  checks = 0;
   int  errors = 0;
   bit  done   = 1'b0;

   priority_enc_4bit dut (
      .clk   (clk),
      .rst   (rst),
      .D     (D),
      .Y     (Y),
      .valid (valid)
   );

   always #5 clk = ~clk;

   // Reference: index of the highest set bit found by repeated halving.
   function automatic expT refModel(input logic [3:0] d);
      expT e;
      int  n;
      int  idx;
      n   = int'(d);
      idx = 0;
      while (n > 1) begin
         n   = n / 2;
         idx = idx + 1;
      end
      e.y = 2'(idx);
      e.v = (d != 4'b0000);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [1:0] actY, input logic actV,
                              input logic [1:0] expY, input logic expV);
      checks++;
      if (actY !== expY || actV !== expV) begin
         errors++;
         $display("[TB] FAIL %s: got Y=%b valid=%b, expected Y=%b valid=%b",
                  name, actY, actV, expY, expV);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] d);
      @(negedge clk);
      D = d;
      expQ.push_back(refModel(d));
   endtask

   // Monitor: every registered output after an unreset edge is scored.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("scoreboard", Y, valid, e.y, e.v);
         end
      end
   end

   task automatic drainQueue();
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
         expQ.delete();
      end
   endtask

   initial begin
      expT e;
      expT prev;
      logic [3:0] sweepVals[$];

      // Reset asserted with all requests high, checked before any clock edge.
      D = 4'b1111;
      #1 rst = 1'b1;
      #1 checkOutput("reset_no_clock", Y, valid, 2'b00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      expQ.push_back(refModel(D));

      for (int d = 1; d < 16; d++) applyStimulus(4'(d));

      applyStimulus(4'b0100);
      applyStimulus(4'b0000);
      applyStimulus(4'b0101);
      applyStimulus(4'b0011);
      applyStimulus(4'b1111);

      for (int i = 0; i < 200; i++) applyStimulus(4'($urandom_range(0, 15)));
      drainQueue();

      // Latency: a mid-cycle D change must not reach Y before the next edge.
      applyStimulus(4'b0001);
      @(posedge clk);
      #3;
      prev = refModel(4'b0001);
      D = 4'b1000;
      #1 checkOutput("latency_hold", Y, valid, prev.y, prev.v);
      @(negedge clk);
      expQ.push_back(refModel(D));
      drainQueue();

      // Mid-run reset while Y=11; D seen during reset must be forgotten.
      applyStimulus(4'b1000);
      @(posedge clk);
      #3 rst = 1'b1;
      D = 4'b0010;
      #1 checkOutput("midrun_reset", Y, valid, 2'b00, 1'b0);
      @(posedge clk);
      #1 checkOutput("reset_held_over_edge", Y, valid, 2'b00, 1'b0);
      @(negedge clk);
      D = 4'b1000;
      rst = 1'b0;
      expQ.push_back(refModel(D));
      drainQueue();

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         errors++;
         $display("[TB] FAIL watchdog: simulation not complete, expected completion");
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

endmodule
